// File: rtl/lfsr_event_timer.sv
// Programmable event timer: a Galois LFSR prescaler emits a base tick once per
// prescale period, and a down-counter of base ticks raises expire (one-shot or periodic).
module lfsr_event_timer #(
   parameter int                LFSR_W   = 16,
   parameter logic [LFSR_W-1:0] TAPS     = 16'h002D,
   parameter logic [LFSR_W-1:0] SEED     = 16'h0001,
   parameter logic [LFSR_W-1:0] TERMINAL = 16'hB11F,
   parameter int                CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             start,
   input  logic             stop,
   input  logic             mode,
   input  logic [CNT_W-1:0] period_in,
   output logic             tick,
   output logic             expire,
   output logic             busy,
   output logic [CNT_W-1:0] remaining
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t            state;
   logic [LFSR_W-1:0] lfsr;
   logic [LFSR_W-1:0] lfsr_step;
   logic [CNT_W-1:0]  period_q;
   logic              mode_q;
   logic              last_tick;

   assign lfsr_step = {lfsr[LFSR_W-2:0], 1'b0} ^ (lfsr[LFSR_W-1] ? TAPS : '0);
   // remaining is always >= 1 in RUN; treating <= 1 as the last tick keeps it from wrapping
   assign last_tick = (remaining <= CNT_W'(1));

   // Control priority each edge: stop, then start (restart), then counting when enabled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         lfsr      <= SEED;
         tick      <= 1'b0;
         expire    <= 1'b0;
         busy      <= 1'b0;
         remaining <= '0;
         period_q  <= '0;
         mode_q    <= 1'b0;
      end else begin
         tick   <= 1'b0;
         expire <= 1'b0;
         if (stop || (start && period_in == '0)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            remaining <= '0;
            lfsr      <= SEED;
         end else if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            remaining <= period_in;
            period_q  <= period_in;
            mode_q    <= mode;
            lfsr      <= SEED;
         end else if (state == RUN && enable) begin
            if (lfsr == TERMINAL) begin
               lfsr <= SEED;
               tick <= 1'b1;
               if (last_tick) begin
                  expire <= 1'b1;
                  if (mode_q) begin
                     remaining <= period_q;
                  end else begin
                     state     <= IDLE;
                     busy      <= 1'b0;
                     remaining <= '0;
                  end
               end else begin
                  remaining <= remaining - 1'b1;
               end
            end else begin
               lfsr <= lfsr_step;
            end
         end
      end
   end

endmodule

// File: tb/tb_lfsr_event_timer.sv
// Bench for lfsr_event_timer: short-terminal instance checked cycle by cycle against a
// phase-counter model, plus instances exercising the feedback taps and default parameters.
module tb_lfsr_event_timer;

   localparam int PA = 4;  // prescale period of instance A: 1 -> 2 -> 4 -> 8, then reload

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enable = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0;
   logic [7:0] period_in = '0;
   logic       a_tick, a_expire, a_busy;
   logic [7:0] a_rem;

   logic       start2 = 1'b0;
   logic [7:0] period_b = 8'd2, period_c = 8'd1;
   logic       b_tick, b_expire, b_busy, c_tick, c_expire, c_busy;
   logic [7:0] b_rem, c_rem;

   always #5 clk = ~clk;

   lfsr_event_timer #(.TERMINAL(16'h0008), .SEED(16'h0001)) dut_a (
      .clk(clk), .rst(rst), .enable(enable), .start(start), .stop(stop), .mode(mode),
      .period_in(period_in), .tick(a_tick), .expire(a_expire), .busy(a_busy), .remaining(a_rem));

   lfsr_event_timer #(.TERMINAL(16'h002D)) dut_b (
      .clk(clk), .rst(rst), .enable(1'b1), .start(start2), .stop(1'b0), .mode(1'b0),
      .period_in(period_b), .tick(b_tick), .expire(b_expire), .busy(b_busy), .remaining(b_rem));

   lfsr_event_timer dut_c (
      .clk(clk), .rst(rst), .enable(1'b1), .start(start2), .stop(1'b0), .mode(1'b0),
      .period_in(period_c), .tick(c_tick), .expire(c_expire), .busy(c_busy), .remaining(c_rem));

   typedef struct {
      int         n;
      logic       en, st, sp, md;
      logic [7:0] per;
      logic       chk;
      logic       exp_busy;
      logic [7:0] exp_rem;
   } vec_t;
   typedef int ev_t [4];

   vec_t       vecs[$];
   logic [10:0] exp_q[$];
   int         tick_log[$], exp_log[$];
   int         checks = 0, failures = 0, cyc = 0;

   // reference model: prescaler as a plain phase counter
   logic       m_run = 1'b0, m_mode = 1'b0, m_tick, m_exp;
   logic [7:0] m_rem = '0, m_per = '0;
   int         m_phase = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   task automatic model_reset();
      m_run = 1'b0; m_mode = 1'b0; m_rem = '0; m_per = '0; m_phase = 0;
      exp_q.delete();
   endtask

   task automatic step(input logic en, st, sp, md, input logic [7:0] per);
      logic [10:0] got, want;
      enable = en; start = st; stop = sp; mode = md; period_in = per;
      m_tick = 1'b0; m_exp = 1'b0;
      if (sp || (st && per == 8'd0)) begin
         m_run = 1'b0; m_rem = '0; m_phase = 0;
      end else if (st) begin
         m_run = 1'b1; m_rem = per; m_per = per; m_mode = md; m_phase = 0;
      end else if (m_run && en) begin
         if (m_phase == PA - 1) begin
            m_phase = 0;
            m_tick  = 1'b1;
            if (m_rem == 8'd1) begin
               m_exp = 1'b1;
               if (m_mode) m_rem = m_per;
               else begin m_run = 1'b0; m_rem = '0; end
            end else begin
               m_rem = m_rem - 8'd1;
            end
         end else begin
            m_phase++;
         end
      end
      exp_q.push_back({m_tick, m_exp, m_run, m_rem});
      @(posedge clk);
      #1;
      got  = {a_tick, a_expire, a_busy, a_rem};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL cycle %0d {tick,expire,busy,rem}: got %03h expected %03h", cyc, got, want);
      end
      if (a_tick)   tick_log.push_back(cyc);
      if (a_expire) exp_log.push_back(cyc);
      cyc++;
   endtask

   function automatic void add(input int n, input logic en, st, sp, md, input logic [7:0] per,
                               input logic chk, eb, input logic [7:0] er);
      vec_t v;
      v.n = n; v.en = en; v.st = st; v.sp = sp; v.md = md; v.per = per;
      v.chk = chk; v.exp_busy = eb; v.exp_rem = er;
      vecs.push_back(v);
   endfunction

   task automatic run_vecs(input string name);
      vec_t v;
      cyc = 0;
      tick_log.delete();
      exp_log.delete();
      while (vecs.size() > 0) begin
         v = vecs.pop_front();
         for (int i = 0; i < v.n; i++) step(v.en, v.st, v.sp, v.md, v.per);
         if (v.chk) begin
            check({name, " busy"}, 32'(a_busy), 32'(v.exp_busy));
            check({name, " remaining"}, 32'(a_rem), 32'(v.exp_rem));
         end
      end
   endtask

   task automatic check_ev(input string name, input int log[$], input ev_t e);
      int  n = 0;
      logic ok;
      for (int i = 0; i < 4; i++) if (e[i] >= 0) n++;
      ok = (log.size() == n);
      for (int i = 0; i < n && ok; i++) ok = (log[i] == e[i]);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got %0d events first=%0d expected %0d events first=%0d",
                  name, log.size(), (log.size() > 0) ? log[0] : -1, n, e[0]);
      end
   endtask

   function automatic int prescale_len(input logic [15:0] taps, seed, term);
      logic [15:0] v = seed;
      for (int i = 0; i < 70000; i++) begin
         if (v == term) return i + 1;
         v = {v[14:0], 1'b0} ^ (v[15] ? taps : 16'h0000);
      end
      return -1;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ev_t e;
      int  b_tk, b_ex, c_tk, c_ex, pc;

      // reset state
      #22;
      check("reset A", 32'({a_tick, a_expire, a_busy, a_rem}), 32'h0);
      check("reset B", 32'({b_tick, b_expire, b_busy, b_rem}), 32'h0);
      check("reset C", 32'({c_tick, c_expire, c_busy, c_rem}), 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // feedback taps (B) and default prescaler (C)
      pc = prescale_len(16'h002D, 16'h0001, 16'hB11F);
      b_tk = -1; b_ex = -1; c_tk = -1; c_ex = -1;
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      check("B busy after start", 32'(b_busy), 32'd1);
      for (int n = 1; n <= 70000; n++) begin
         @(posedge clk);
         #1;
         if (b_tick && b_tk < 0) b_tk = n;
         if (b_expire && b_ex < 0) b_ex = n;
         if (c_tick && c_tk < 0) c_tk = n;
         if (c_expire) begin c_ex = n; break; end
      end
      check("B first tick edge", 32'(b_tk), 32'd17);
      check("B expire edge", 32'(b_ex), 32'd34);
      check("C tick edge", 32'(c_tk), 32'(pc));
      check("C expire edge", 32'(c_ex), 32'(pc));
      check("C busy after expire", 32'(c_busy), 32'd0);

      // one-shot, period 3
      add(1, 1, 1, 0, 0, 3, 1, 1, 3);
      add(14, 1, 0, 0, 0, 0, 1, 0, 0);
      run_vecs("oneshot");
      e = '{4, 8, 12, -1}; check_ev("oneshot ticks", tick_log, e);
      e = '{12, -1, -1, -1}; check_ev("oneshot expire", exp_log, e);

      // periodic, period 3
      add(1, 1, 1, 0, 1, 3, 1, 1, 3);
      add(37, 1, 0, 0, 0, 0, 1, 1, 3);
      add(1, 1, 0, 1, 0, 0, 1, 0, 0);
      run_vecs("periodic");
      e = '{12, 24, 36, -1}; check_ev("periodic expire", exp_log, e);

      // pause
      add(1, 1, 1, 0, 0, 3, 1, 1, 3);
      add(6, 1, 0, 0, 0, 0, 1, 1, 2);
      add(5, 0, 0, 0, 0, 0, 1, 1, 2);
      add(8, 1, 0, 0, 0, 0, 1, 0, 0);
      run_vecs("pause");
      e = '{4, 13, 17, -1}; check_ev("pause ticks", tick_log, e);
      e = '{17, -1, -1, -1}; check_ev("pause expire", exp_log, e);

      // restart with period 2
      add(1, 1, 1, 0, 0, 3, 1, 1, 3);
      add(9, 1, 0, 0, 0, 0, 1, 1, 1);
      add(1, 1, 1, 0, 0, 2, 1, 1, 2);
      add(9, 1, 0, 0, 0, 0, 1, 0, 0);
      run_vecs("restart");
      e = '{4, 8, 14, 18}; check_ev("restart ticks", tick_log, e);
      e = '{18, -1, -1, -1}; check_ev("restart expire", exp_log, e);

      // stop wins over start
      add(1, 1, 1, 0, 0, 3, 1, 1, 3);
      add(9, 1, 0, 0, 0, 0, 1, 1, 1);
      add(1, 1, 1, 1, 0, 2, 1, 0, 0);
      add(5, 1, 0, 0, 0, 0, 1, 0, 0);
      run_vecs("stopstart");
      e = '{-1, -1, -1, -1}; check_ev("stopstart expire", exp_log, e);

      // zero period: ignored in idle, acts as stop in run
      add(1, 1, 1, 0, 0, 0, 1, 0, 0);
      add(4, 1, 0, 0, 0, 0, 1, 0, 0);
      add(1, 1, 1, 0, 0, 3, 1, 1, 3);
      add(2, 1, 0, 0, 0, 0, 1, 1, 3);
      add(1, 1, 1, 0, 0, 0, 1, 0, 0);
      add(5, 1, 0, 0, 0, 0, 1, 0, 0);
      run_vecs("zeroper");
      e = '{-1, -1, -1, -1}; check_ev("zeroper ticks", tick_log, e);

      // stop and start honoured while enable is low
      add(1, 1, 1, 0, 0, 5, 1, 1, 5);
      add(5, 1, 0, 0, 0, 0, 1, 1, 4);
      add(2, 0, 0, 0, 0, 0, 1, 1, 4);
      add(1, 0, 0, 1, 0, 0, 1, 0, 0);
      add(1, 0, 1, 0, 1, 2, 1, 1, 2);
      add(3, 0, 0, 0, 0, 0, 1, 1, 2);
      add(8, 1, 0, 0, 0, 0, 1, 1, 2);
      run_vecs("paused ctl");

      // maximum period, and period 1 periodic
      add(1, 1, 1, 0, 0, 255, 1, 1, 255);
      add(1019, 1, 0, 0, 0, 0, 1, 1, 1);
      add(1, 1, 0, 0, 0, 0, 1, 0, 0);
      run_vecs("maxper");
      e = '{1020, -1, -1, -1}; check_ev("maxper expire", exp_log, e);
      add(1, 1, 1, 0, 1, 1, 1, 1, 1);
      add(8, 1, 0, 0, 0, 0, 1, 1, 1);
      add(1, 1, 0, 1, 0, 0, 1, 0, 0);
      run_vecs("per1");
      e = '{4, 8, -1, -1}; check_ev("per1 expire", exp_log, e);

      // random traffic against the model
      for (int i = 0; i < 300; i++)
         add(1, ($urandom_range(0, 9) != 0), ($urandom_range(0, 24) == 0),
             ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 4)), 0, 0, 0);
      run_vecs("random");

      // asynchronous reset mid-run, landing while tick is high
      add(1, 1, 1, 0, 1, 3, 1, 1, 3);
      add(4, 1, 0, 0, 0, 0, 1, 1, 2);
      run_vecs("prereset");
      check("tick before reset", 32'(a_tick), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("async reset outputs", 32'({a_tick, a_expire, a_busy, a_rem}), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      add(12, 1, 0, 0, 0, 0, 1, 0, 0);
      run_vecs("postreset");
      e = '{-1, -1, -1, -1}; check_ev("postreset ticks", tick_log, e);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
